ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_if.sv | 43 ++++
 rtl/ex_muldiv.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if -- request/response bundle of the M-extension execute unit.
//
// Signals
//   start       : M-extension op valid from the dec/ex register this cycle
//   op[2:0]     : funct3 (000 MUL .. 111 REMU)
//   rs1_p/rs2_p : forwarded operands A and B
//   rd_ad_p     : destination register of the op
//   kill        : flush the in-flight op (branch redirect)
//   result      : final value, valid while done=1, held afterwards
//   rd_out      : destination register of the completed op, held afterwards
//   done        : one-cycle completion pulse
//   busy        : unit is not idle
//   stall       : hold the upstream pipeline
//   unsupported : op not built into this configuration, valid with done
//
// Modports: master drives the request side (pipeline / bench), slave is the
// execute unit itself.
// ---------------------------------------------------------------------------
interface ex_muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_p;
    logic [31:0] rs2_p;
    logic [4:0]  rd_ad_p;
    logic        kill;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        done;
    logic        busy;
    logic        stall;
    logic        unsupported;

    modport master (
        output start, op, rs1_p, rs2_p, rd_ad_p, kill,
        input  result, rd_out, done, busy, stall, unsupported
    );

    modport slave (
        input  start, op, rs1_p, rs2_p, rd_ad_p, kill,
        output result, rd_out, done, busy, stall, unsupported
    );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- multi-cycle RV32 M-extension execute unit.
//
// Ports
//   clk   : single clock, all state changes on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : ex_muldiv_if.slave (start/op/operands/rd/kill in,
//           result/rd_out/done/busy/stall/unsupported out)
//
// Parameter
//   MUL_STAGES : cycles from accept to done for multiplies, 1..3
//
// Build option
//   MULDIV_DIV_EN : when defined, builds the restoring divider for the
//                   DIV/DIVU/REM/REMU ops. When undefined those ops finish on
//                   the next edge with result 0 and unsupported=1.
//
// FSM: IDLE -> MUL/DIV -> DONE (one cycle, done=1) -> IDLE.
// Divide timeline (cnt_q in DIV): 0 setup/bypass, 1..32 iterate,
// 33 sign fixup, 34 commit into DONE -> done 35 cycles after accept.
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int MUL_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;          // op[2] only steers the accept, not needed later
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic [4:0]  rd_out_q;
    logic        unsup_q;

    logic        accept_s, commit_s, div_exit_s;
    logic        a_sgn_s, b_sgn_s;
    logic [63:0] a_ext_s, b_ext_s, prod_s;
    logic [31:0] mul_res_s;
    logic        done_s, busy_s, stall_s;

    assign accept_s = (state_q == S_IDLE) && bus.start && !bus.kill;
    assign commit_s = (state_d == S_DONE);

    // Multiplier: sign-extend to 64 bits so one unsigned product covers all
    // signedness mixes; only the low 64 bits are ever needed.
    always_comb begin
        a_sgn_s = (op_q == 2'b01) || (op_q == 2'b10);
        b_sgn_s = (op_q == 2'b01);
        a_ext_s = {{32{a_sgn_s & a_q[31]}}, a_q};
        b_ext_s = {{32{b_sgn_s & b_q[31]}}, b_q};
        prod_s  = a_ext_s * b_ext_s;
        if (op_q == 2'b00) begin
            mul_res_s = prod_s[31:0];
        end else begin
            mul_res_s = prod_s[63:32];
        end
    end

`ifdef MULDIV_DIV_EN
    localparam logic [5:0] DIV_ITER_LAST = 6'd32;
    localparam logic [5:0] DIV_FIX       = 6'd33;
    localparam logic [5:0] DIV_LAST      = 6'd34;

    logic [31:0] quo_q, rem_q, dvs_q;
    logic        a_neg_s, b_neg_s, dz_s, ovf_s, div_ok_s;
    logic [31:0] a_mag_s, b_mag_s, div_res_s;
    logic [32:0] rem_sh_s;
    logic [33:0] diff_s;

    // Divider datapath: magnitudes, special cases and one restoring step.
    always_comb begin
        a_neg_s = !op_q[0] && a_q[31];
        b_neg_s = !op_q[0] && b_q[31];
        if (a_neg_s) begin
            a_mag_s = 32'd0 - a_q;
        end else begin
            a_mag_s = a_q;
        end
        if (b_neg_s) begin
            b_mag_s = 32'd0 - b_q;
        end else begin
            b_mag_s = b_q;
        end
        dz_s     = (b_q == 32'd0);
        ovf_s    = !op_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        rem_sh_s = {rem_q, quo_q[31]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, dvs_q};
        // Trial subtract fits iff the 34-bit difference is below 2^32.
        div_ok_s = ~(diff_s[33] | diff_s[32]);
        if ((cnt_q == 6'd0) && dz_s) begin
            div_res_s = op_q[1] ? a_q : 32'hFFFF_FFFF;
        end else if ((cnt_q == 6'd0) && ovf_s) begin
            div_res_s = op_q[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            div_res_s = op_q[1] ? rem_q : quo_q;
        end
        div_exit_s = ((cnt_q == 6'd0) && (dz_s || ovf_s)) || (cnt_q == DIV_LAST);
    end
`else
    // No divider: divide ops leave DIV after a single cycle.
    always_comb begin
        div_exit_s = 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill in MUL/DIV abandons the op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = bus.op[2] ? S_DIV : S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else if (div_exit_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        done_s  = (state_q == S_DONE);
        busy_s  = (state_q != S_IDLE);
        stall_s = ((state_q == S_IDLE) && bus.start) ||
                  (state_q == S_MUL) || (state_q == S_DIV);
    end

    // Operand capture, cycle counter, divider steps and committed outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 6'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 2'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
            unsup_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 6'd0;
                    if (accept_s) begin
                        a_q  <= bus.rs1_p;
                        b_q  <= bus.rs2_p;
                        op_q <= bus.op[1:0];
                        rd_q <= bus.rd_ad_p;
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (commit_s) begin
                        result_q <= mul_res_s;
                        rd_out_q <= rd_q;
                        unsup_q  <= 1'b0;
                    end
                end
                S_DIV: begin
`ifdef MULDIV_DIV_EN
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd0) begin
                        quo_q <= a_mag_s;
                        rem_q <= 32'd0;
                        dvs_q <= b_mag_s;
                    end else if (cnt_q <= DIV_ITER_LAST) begin
                        quo_q <= {quo_q[30:0], div_ok_s};
                        rem_q <= div_ok_s ? diff_s[31:0] : rem_sh_s[31:0];
                    end else if (cnt_q == DIV_FIX) begin
                        if (a_neg_s ^ b_neg_s) begin
                            quo_q <= 32'd0 - quo_q;
                        end
                        if (a_neg_s) begin
                            rem_q <= 32'd0 - rem_q;
                        end
                    end
                    if (commit_s) begin
                        result_q <= div_res_s;
                        rd_out_q <= rd_q;
                        unsup_q  <= 1'b0;
                    end
`else
                    if (commit_s) begin
                        result_q <= 32'd0;
                        rd_out_q <= rd_q;
                        unsup_q  <= 1'b1;
                    end
`endif
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign bus.result      = result_q;
    assign bus.rd_out      = rd_out_q;
    assign bus.unsupported = unsup_q;
    assign bus.done        = done_s;
    assign bus.busy        = busy_s;
    assign bus.stall       = stall_s;

endmodule
